// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: bus widths, the reserved
// "no dependency" tag, requester indices and the cdb_src width.
package cdb_arbiter_pkg;

  localparam int unsigned CdbDataWidth = 32;
  localparam int unsigned CdbTagWidth  = 32;
  localparam int unsigned CdbSrcWidth  = 3;

  // Tag value meaning "no dependency"; never broadcast.
  localparam int unsigned TagNone = 0;

  localparam int unsigned ReqAlu = 0;
  localparam int unsigned ReqLsb = 1;
  localparam int unsigned ReqBr  = 2;

  // Pointer width for a round-robin index over n requesters (at least 1 bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin find-first-set: scans req_i starting at ptr_i,
// wrapping modulo NumReq, and returns a one-hot grant plus its index.
module cdb_arbiter_rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = 3,
  parameter int unsigned PtrWidth = ptr_width(NumReq)
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [PtrWidth-1:0] ptr_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [PtrWidth-1:0] idx_o,
  output logic                any_o
);

  int unsigned         cand;
  logic                found;
  logic [NumReq-1:0]   gnt;
  logic [PtrWidth-1:0] idx;

  // First requester at or after the pointer wins; later ones are masked.
  always_comb begin
    cand  = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(ptr_i) + k) % NumReq;
      if (!found && req_i[cand[PtrWidth-1:0]]) begin
        found                   = 1'b1;
        gnt[cand[PtrWidth-1:0]] = 1'b1;
        idx                     = cand[PtrWidth-1:0];
      end
    end
  end

  assign gnt_o = gnt;
  assign idx_o = idx;
  assign any_o = found;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per result producer, occupied
// buffers granted round-robin, one registered (tag, data) broadcast per cycle.
// flush clears all pending results synchronously.
// Optional: define CDB_BYPASS_EN to let an empty requester with a live result
// arbitrate in the same cycle, cutting uncontested latency from 2 to 1.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned DataWidth = CdbDataWidth,
  parameter int unsigned TagWidth  = CdbTagWidth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NumReq-1:0]             req_valid,
  input  logic [NumReq*TagWidth-1:0]    req_tag,
  input  logic [NumReq*DataWidth-1:0]   req_data,
  output logic [NumReq-1:0]             req_ready,
  output logic                          cdb_valid,
  output logic [TagWidth-1:0]           cdb_tag,
  output logic [DataWidth-1:0]          cdb_data,
  output logic [CdbSrcWidth-1:0]        cdb_src
);

  localparam int unsigned PtrWidth = ptr_width(NumReq);

  logic [NumReq-1:0]      occ_q, occ_d;
  logic [TagWidth-1:0]    buf_tag_q  [NumReq];
  logic [TagWidth-1:0]    buf_tag_d  [NumReq];
  logic [DataWidth-1:0]   buf_data_q [NumReq];
  logic [DataWidth-1:0]   buf_data_d [NumReq];
  logic [PtrWidth-1:0]    rr_ptr_q, rr_ptr_d;
  logic                   cdb_valid_q, cdb_valid_d;
  logic [TagWidth-1:0]    cdb_tag_q, cdb_tag_d;
  logic [DataWidth-1:0]   cdb_data_q, cdb_data_d;
  logic [CdbSrcWidth-1:0] cdb_src_q, cdb_src_d;

  logic [TagWidth-1:0]    in_tag    [NumReq];
  logic [DataWidth-1:0]   in_data   [NumReq];
  logic [NumReq-1:0]      in_live;
  logic [TagWidth-1:0]    cand_tag  [NumReq];
  logic [DataWidth-1:0]   cand_data [NumReq];
  logic [NumReq-1:0]      arb_req;
  logic [NumReq-1:0]      byp;
  logic [NumReq-1:0]      gnt;
  logic [PtrWidth-1:0]    gnt_idx;
  logic                   gnt_any;

  // Unpack the requester buses; a live result is valid with a real tag.
  always_comb begin
    in_live = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      in_tag[i]  = req_tag[i*TagWidth +: TagWidth];
      in_data[i] = req_data[i*DataWidth +: DataWidth];
      in_live[i] = req_valid[i] && (in_tag[i] != TagWidth'(TagNone));
    end
  end

  // Arbitration candidates: buffered entries, plus live inputs of empty buffers with bypass.
  always_comb begin
    arb_req = occ_q;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand_tag[i]  = buf_tag_q[i];
      cand_data[i] = buf_data_q[i];
    end
`ifdef CDB_BYPASS_EN
    arb_req = occ_q | in_live;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!occ_q[i]) begin
        cand_tag[i]  = in_tag[i];
        cand_data[i] = in_data[i];
      end
    end
`endif
  end

  cdb_arbiter_rr_picker #(
    .NumReq   (NumReq),
    .PtrWidth (PtrWidth)
  ) u_picker (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // A bypass grant goes straight to the bus and never touches the buffer.
  assign byp = gnt & ~occ_q;

  // A buffer being drained this cycle can be refilled in the same cycle.
  assign req_ready = flush ? '0 : (~occ_q | gnt);

  // Next-state: buffer fill/drain, broadcast register and pointer advance.
  always_comb begin
    occ_d       = occ_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = '0;
    cdb_data_d  = '0;
    cdb_src_d   = cdb_src_q;
    if (flush) begin
      occ_d    = '0;
      rr_ptr_d = '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        // Tag-0 pushes are accepted but fall through here and are dropped.
        if (in_live[i] && req_ready[i] && !byp[i]) begin
          occ_d[i]      = 1'b1;
          buf_tag_d[i]  = in_tag[i];
          buf_data_d[i] = in_data[i];
        end else if (gnt[i]) begin
          occ_d[i] = 1'b0;
        end
      end
      if (gnt_any) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = cand_tag[gnt_idx];
        cdb_data_d  = cand_data[gnt_idx];
        cdb_src_d   = CdbSrcWidth'(gnt_idx);
        rr_ptr_d    = (gnt_idx == PtrWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
        buf_tag_q[i]  <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      occ_q       <= occ_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among result producers: ALU (0), load/store buffer (1), branch unit (2).
- The CDB feeds operand wakeup in the reservation stations and ROB. Each CDB entry is a (tag, data) pair.
- Each producer gets a 1-entry holding buffer. Occupied buffers are granted round-robin, one broadcast per cycle.
- The output is registered. The block is cleared by the ROB exception/flush signal.

Parameters:
- NumReq, 3, number of requesters (1..8).
- DataWidth, 32, result width.
- TagWidth, 32, tag width. Tag = ROB pc/tag; value 0 reserved as "no dependency".

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  ROB exception, synchronous clear.
- req_valid  in  NumReq  per-requester result valid.
- req_tag  in  NumReq*TagWidth  packed; slice i = requester i.
- req_data  in  NumReq*DataWidth  packed.
- req_ready  out  NumReq  buffer i can accept this cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TagWidth  broadcast tag.
- cdb_data  out  DataWidth  broadcast value.
- cdb_src  out  3  index of the granted requester.

Behaviour:
- Reset (rst=0, asynchronous):
  - all buffers empty, rr_ptr=0;
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - Reset mid-operation discards all pending results.
- State: occ[i], buf_tag[i], buf_data[i], rr_ptr (0..NumReq-1).
- Grant (combinational):
  - grant = first i with occ[i]=1, scanning rr_ptr, rr_ptr+1, …, wrapping modulo NumReq. At most one grant per cycle.
- req_ready[i] = !occ[i] || grant[i].
  - No req_ready bit depends on its own req_valid.
  - req_ready is forced 0 while flush=1.
- Push (req_valid[i] && req_ready[i]) writes the buffer at the next edge.
  - A push and a grant on the same buffer in the same cycle: the buffer is refilled, stays occupied, and the old entry is broadcast.
- Tag 0: a push with tag 0 is accepted and dropped (buffer not set). Tag 0 is never broadcast.
- On a grant, at the next edge:
  - cdb_valid<=1, cdb_tag/cdb_data<=buffer contents, cdb_src<=i;
  - occ[i] cleared unless refilled;
  - rr_ptr <= (i+1) mod NumReq.
- No grant: cdb_valid<=0, cdb_tag<=0, cdb_data<=0; cdb_src and rr_ptr hold.
- Latency: push accepted at cycle t → earliest broadcast visible at t+2.
- Fairness: an occupied buffer is broadcast within NumReq cycles.
- No CDB backpressure; consumers always accept.
- flush=1 (priority over everything):
  - at the next edge: all occ cleared, cdb_valid<=0, cdb_tag/data<=0, rr_ptr<=0;
  - pushes in the flush cycle are dropped;
  - the broadcast already on the bus during the flush cycle is still visible to consumers (they flush in the same cycle).
- NumReq=1: rr_ptr constant 0; the block degenerates to a registered 1-entry skid.

Optional Feature:
- CDB_BYPASS_EN defined:
  - A requester with an empty buffer and req_valid=1 (tag≠0) joins arbitration in the same cycle, using req_tag/req_data directly.
  - If granted: broadcast at t+1, and the buffer is not written.
  - If not granted: the entry is buffered as normal.
  - Latency drops to 1 for uncontested results.
  - req_ready[i] for an occupied i may now depend on other requesters' req_valid, never its own.
- Undefined: two-cycle path as above; no combinational path from req_* to the grant.

Decomposition:
- Shared package (parameters.v additions):
  - CDB data/tag width macros;
  - TagNone=0;
  - requester index constants ReqAlu=0, ReqLsb=1, ReqBr=2;
  - cdb_src width macro.
- One natural sub-module: rr_picker, a combinational find-first-set starting at rr_ptr with wrap. It takes a request vector and a pointer, and returns a one-hot grant and its index.

Test Plan:
1. Reset with rst=0 mid-traffic (buffers 0,2 occupied) → all outputs 0 immediately; after rst=1, no stale broadcast; req_ready=3'b111.
2. Single push: ALU, tag=0x14, data=0xDEADBEEF at cycle t → cdb_valid=1, tag=0x14, data=0xDEADBEEF, src=0 at t+2 (t+1 with CDB_BYPASS_EN); cdb_valid=0 the following cycle.
3. All three push at t (tags 0x10/0x20/0x30), rr_ptr=0 → broadcasts 0x10, 0x20, 0x30 on t+2..t+4, src 0,1,2; rr_ptr wraps to 0.
4. Continuous ALU pushes every cycle plus one LSB push (tag 0x40) → LSB broadcast within 3 cycles; ALU req_ready stays 1 (refill on grant); no entry lost or duplicated.
5. Buffers 0,1 occupied, flush=1 for one cycle with a new branch push (tag 0x50) → next cycle cdb_valid=0, req_ready=111, tag 0x50 never broadcast; rr_ptr=0.
6. Push with tag=0, data=0x1234 → accepted (req_ready=1), never broadcast; buffer remains empty.
